// File: rtl/cpu_ad48_dmem_resp.sv
// Data-memory responder for the cpu_ad48 load/store path: one outstanding 48-bit
// LD/ST transaction, response returned after LATENCY wait states.
module cpu_ad48_dmem_resp #(
    parameter int WORDS   = 128,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [47:0] req_addr,
    input  logic [47:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [47:0] rsp_rdata,
    output logic        rsp_we,
    output logic        rsp_err
);

    localparam int          AW      = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [3:0]  LAT_C   = 4'(LATENCY);
    localparam logic [47:0] WORDS_C = 48'(WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Full-width compare: an address past the array never aliases onto a real word.
    function automatic logic addr_in_range(input logic [47:0] addr);
        return (addr < WORDS_C);
    endfunction

    reg [47:0] mem [0:WORDS-1];

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [47:0] rdata_q, rdata_d;
    logic        we_q, we_d;
    logic        err_q, err_d;

    logic          accept_s;
    logic          in_range_s;
    logic [AW-1:0] idx_s;
    logic          wr_en_s;

    assign accept_s   = req_valid && (state_q == ST_IDLE) && !rst;
    assign in_range_s = addr_in_range(req_addr);
    assign idx_s      = req_addr[AW-1:0];
    assign wr_en_s    = accept_s && req_we && in_range_s;

    // Array write: committed at accept and deliberately untouched by reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem[idx_s] <= req_wdata;
        end
    end

    // State and wait-state counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; a count of 0 in WAIT is treated like 1 so the FSM can never stall.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    if (LAT_C == 4'd0) begin
                        state_d = ST_RESP;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = LAT_C;
                    end
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end
            end
            ST_WAIT: begin
                cnt_d = (cnt_q == 4'd0) ? 4'd0 : (cnt_q - 4'd1);
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Response payload capture at accept; held until the next accept.
    always_comb begin
        rdata_d = rdata_q;
        we_d    = we_q;
        err_d   = err_q;
        if (accept_s) begin
            we_d  = req_we;
            err_d = !in_range_s;
            if (in_range_s && !req_we) begin
                rdata_d = mem[idx_s];
            end else begin
                rdata_d = 48'd0;
            end
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Response payload registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= 48'd0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

    // Handshake outputs decoded from state; ready is withheld while reset is held.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = !rst;
                rsp_valid = 1'b0;
            end
            ST_WAIT: begin
                req_ready = 1'b0;
                rsp_valid = 1'b0;
            end
            ST_RESP: begin
                req_ready = 1'b0;
                rsp_valid = 1'b1;
            end
            default: begin
                req_ready = 1'b0;
                rsp_valid = 1'b0;
            end
        endcase
    end

    assign rsp_rdata = rdata_q;
    assign rsp_we    = we_q;
    assign rsp_err   = err_q;

endmodule
